divider: RTL
============

# divider

Sequential unsigned integer divider; the inverse partner of the team's registered 16-bit multiplier datapath. Accepts a dividend/divisor pair over a valid/ready handshake and computes quotient and remainder by restoring division, one bit per clock. Results are presented over a second valid/ready handshake and held until consumed. It sits next to the multiplier so products can be checked or factored back into their operands.

## Interface
- `WIDTH`, default 16: operand, quotient and remainder width in bits (≥2).
- `clk`  input  1: single clock; all state updates on its rising edge.
- `rst_n`  input  1: reset, asynchronous assert, active-low.
- `in_valid`  input  1: request carries a valid operand pair.
- `in_ready`  output  1: divider can accept a request.
- `dividend`  input  WIDTH: unsigned dividend.
- `divisor`  input  WIDTH: unsigned divisor.
- `out_valid`  output  1: result is valid.
- `out_ready`  input  1: consumer accepts the result.
- `quotient`  output  WIDTH: unsigned quotient.
- `remainder`  output  WIDTH: unsigned remainder.
- `div_by_zero`  output  1: result came from a zero divisor; valid with `out_valid`.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`, latch `dividend` into the quotient/shift register, `divisor` into the divisor register, and clear the partial remainder.
  - If divisor ≠ 0: go to BUSY, iteration counter = WIDTH-1.
  - If divisor = 0: go to DONE with quotient = all ones, remainder = dividend, `div_by_zero`=1.
- BUSY: each cycle, shift {rem, quo} left by 1. Trial = rem_shifted − divisor, computed at WIDTH+1 bits. If trial ≥ 0, rem = trial and quo LSB = 1; otherwise rem is restored and quo LSB = 0. When the counter reaches 0, go to DONE; otherwise decrement.
- DONE: `out_valid`=1. `quotient`, `remainder` and `div_by_zero` are stable. On `out_valid && out_ready`, go to IDLE.
- `in_ready` is 0 in BUSY and DONE. There is no bypass, so a new request is never accepted in the same cycle a result is consumed.
- Inputs are ignored except at the acceptance edge. Changes to `dividend`/`divisor` during BUSY have no effect.
- Invariant on every non-zero-divisor result: quotient·divisor + remainder = dividend, with remainder < divisor.

## Timing
- Reset (`rst_n`=0, any time, asynchronous): state = IDLE, `in_ready`=1, `out_valid`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0. Iteration counter and divisor register are cleared.
- Reset mid-BUSY or mid-DONE discards the operation. No result is emitted after reset release.
- Acceptance at edge k with a non-zero divisor: BUSY during cycles k+1 … k+WIDTH, `out_valid` rises after edge k+WIDTH. Latency is WIDTH cycles (16 by default).
- Zero divisor: `out_valid` rises after edge k+1. Latency is 1 cycle.
- Result consumed at edge m: `in_ready` is high after edge m. The earliest next acceptance is edge m+1.
- Minimum request spacing with `out_ready` held high: WIDTH+2 cycles.
- `out_ready` held low: DONE persists indefinitely with outputs frozen.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Structure
- Package `div_pkg`: state enum typedef `div_state_t` (IDLE, BUSY, DONE) and the default width constant `DIV_WIDTH` = 16.
- Sub-module `divider_step`: purely combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Instantiated once; the top level holds state, counter and handshake.

## Test plan
- 100 ÷ 7 with `out_ready`=1 → after 16 cycles `out_valid`=1, quotient=14, remainder=2, `div_by_zero`=0.
- 0xFFFF ÷ 1 → quotient=0xFFFF, remainder=0. Then 3 ÷ 0xFFFF → quotient=0, remainder=3.
- 5 ÷ 0 → `out_valid` one cycle after acceptance, quotient=0xFFFF, remainder=5, `div_by_zero`=1.
- Backpressure: 1000 ÷ 33, `out_ready`=0 for 10 cycles after `out_valid` → outputs hold 30/10 and `in_ready`=0 throughout. Accept on the cycle `out_ready` rises; `in_ready` returns the next cycle.
- `rst_n` pulsed low at the 5th BUSY cycle of 500 ÷ 9 → immediate IDLE with all outputs 0, and no `out_valid` afterward. A following 500 ÷ 9 yields 55/5.
- `in_valid` held high with 200 random pairs, including divisor 0 and dividend < divisor, and random `out_ready` → each result matches the invariant. Results arrive in order, none are dropped, and spacing is ≥ WIDTH+2 cycles.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  // Operand width used when the divider is instantiated without overrides.
  localparam int DIV_WIDTH = 16;

  // Controller states: waiting for operands, iterating, holding a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration: shift {rem, quo} left by one bit, try to
// subtract the divisor from the widened remainder, keep the difference if it
// did not borrow and record the outcome in the new quotient LSB.
module divider_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic             borrow;
  // The top trial bit is always zero when no borrow occurs because the
  // incoming remainder is already smaller than the divisor.
  logic             unused_trial_msb;

  // Shift, trial-subtract one bit wider than the operands, then restore or keep.
  always_comb begin
    rem_shift         = {rem, quo[WIDTH-1]};
    {borrow, trial}   = {1'b0, rem_shift} - {2'b00, divisor};
    quo_next          = {quo[WIDTH-2:0], ~borrow};
    rem_next          = borrow ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
    unused_trial_msb  = trial[WIDTH];
  end

endmodule

// File: rtl/divider.sv
// Sequential unsigned divider with valid/ready handshakes on both sides.
// Non-zero divisors take WIDTH restoring iterations, one per clock; a zero
// divisor is resolved at acceptance (quotient all ones, remainder = dividend).
module divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  div_state_t       state_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [CW-1:0]    cnt_reg;
  logic             dbz_reg;

  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] rem_next;

  divider_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem      (rem_reg),
    .quo      (quo_reg),
    .divisor  (dvs_reg),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // Handshake flags decode straight from state so no input reaches an output.
  always_comb begin
    in_ready    = (state_reg == IDLE);
    out_valid   = (state_reg == DONE);
    quotient    = quo_reg;
    remainder   = rem_reg;
    div_by_zero = dbz_reg;
  end

  // Controller and datapath registers: accept, iterate, hold until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      quo_reg   <= '0;
      rem_reg   <= '0;
      dvs_reg   <= '0;
      cnt_reg   <= '0;
      dbz_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            dvs_reg <= divisor;
            if (divisor == '0) begin
              quo_reg   <= '1;
              rem_reg   <= dividend;
              dbz_reg   <= 1'b1;
              state_reg <= DONE;
            end else begin
              quo_reg   <= dividend;
              rem_reg   <= '0;
              dbz_reg   <= 1'b0;
              cnt_reg   <= CW'(WIDTH - 1);
              state_reg <= BUSY;
            end
          end
        end
        BUSY: begin
          quo_reg <= quo_next;
          rem_reg <= rem_next;
          if (cnt_reg == '0) begin
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
